// File: rtl/pwm_demodulator_if.sv
// pwm_demodulator_if: receive-side PWM line, enable and recovered-sample outputs.
interface pwm_demodulator_if #(
    parameter int PERIOD_W = 8
);
    logic                en;
    logic                pwm_in;
    logic [PERIOD_W-1:0] data_out;
    logic                data_valid;
    logic                locked;
    logic                sync_err;

    modport master (
        output en, pwm_in,
        input  data_out, data_valid, locked, sync_err
    );

    modport slave (
        input  en, pwm_in,
        output data_out, data_valid, locked, sync_err
    );
endinterface

// File: rtl/pwm_demodulator.sv
// pwm_demodulator: recovers PWM samples by counting high cycles per 2^PERIOD_W-clock frame.
// Optional PWM_GLITCH_FILTER_EN inserts a 3-sample majority filter before edge detection.
module pwm_demodulator #(
    parameter int PERIOD_W    = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic              clk,
    input logic              rst,
    pwm_demodulator_if.slave bus
);
    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [PERIOD_W-1:0] LAST = '1;
    localparam logic [PERIOD_W-1:0] ONE  = 1;
    localparam logic [PERIOD_W:0]   HONE = 1;

    typedef enum logic {IDLE, MEASURE} state_e;

    state_e              state_q, state_d;
    logic [SS-1:0]       sync_q;
    logic                s, s_prev_q, rise;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W:0]   hcnt_q, hcnt_d, total;
    logic [PERIOD_W-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                locked_q, locked_d;
    logic                err_q, err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= {sync_q[SS-2:0], bus.pwm_in};
    end

`ifdef PWM_GLITCH_FILTER_EN
    logic [2:0] filt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) filt_q <= '0;
        else      filt_q <= {filt_q[1:0], sync_q[SS-1]};
    end
    assign s = (filt_q[0] & filt_q[1]) | (filt_q[1] & filt_q[2]) | (filt_q[0] & filt_q[2]);
`else
    assign s = sync_q[SS-1];
`endif

    assign rise  = s & ~s_prev_q;
    assign total = hcnt_q + {{PERIOD_W{1'b0}}, s};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        locked_d = locked_q;
        if (!bus.en) begin
            state_d  = IDLE;
            cnt_d    = '0;
            hcnt_d   = '0;
            locked_d = 1'b0;
        end else if (state_q == IDLE) begin
            if (rise) begin
                state_d = MEASURE;
                cnt_d   = ONE;
                hcnt_d  = HONE;
            end
        end else if (rise && cnt_q != '0) begin
            // an edge mid-frame means we are misaligned: restart the frame on it
            err_d    = 1'b1;
            locked_d = 1'b0;
            cnt_d    = ONE;
            hcnt_d   = HONE;
        end else if (cnt_q == LAST) begin
            data_d   = total[PERIOD_W] ? LAST : total[PERIOD_W-1:0];
            valid_d  = 1'b1;
            locked_d = 1'b1;
            cnt_d    = '0;
            hcnt_d   = '0;
        end else begin
            cnt_d  = cnt_q + ONE;
            hcnt_d = total;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            s_prev_q <= 1'b0;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_prev_q <= s;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.locked     = locked_q;
    assign bus.sync_err   = err_q;
endmodule

// File: doc/pwm_demodulator.md
Name: pwm_demodulator

Overview:
Receive-side counterpart of the modulator/PWM transmit chain. Samples the PWM waveform on the GPIO pin and measures high time per PWM frame (2^PERIOD_W clocks) to recover the 8-bit sample value the transmitter encoded. Aligns to frame start on rising edges and flags realignment events. Output feeds the receive-side demodulator logic.

Parameters:
PERIOD_W, 8, log2 of PWM frame length in clocks; frame = 2^PERIOD_W cycles; data_out width = PERIOD_W
SYNC_STAGES, 2, number of flops in the pwm_in synchronizer (min 2)

Ports:
clk  input  1  system clock, same frequency as transmitter PWM clock
rst  input  1  asynchronous reset, active-low (asserted when 0)
en  input  1  receive enable; 0 forces IDLE
pwm_in  input  1  asynchronous PWM line from GPIO
data_out  output  PERIOD_W  last recovered sample (high-cycle count of a frame)
data_valid  output  1  one-cycle strobe; data_out updated this cycle
locked  output  1  frame alignment established
sync_err  output  1  one-cycle strobe; unexpected rising edge mid-frame

Behaviour:
- Reset (rst=0, async): synchronizer, edge flop, counters cleared; data_out=0, data_valid=0, locked=0, sync_err=0, state=IDLE.
- s = synchronizer output; rise = s & ~s_prev (s_prev reset 0).
- Counters: cnt (PERIOD_W bits, cycle index in frame); hcnt (PERIOD_W+1 bits, high cycles).
- IDLE: wait for rise -> MEASURE, cnt<=1, hcnt<=1. Nothing else updates.
- MEASURE, per cycle, priority order:
  1. rise && cnt!=0: abort frame, no data_valid; sync_err<=1 for one cycle; locked<=0; cnt<=1, hcnt<=1 (frame restarts at this edge).
  2. cnt==2^PERIOD_W-1 (last cycle): total = hcnt+s; data_out <= saturate(total, 2^PERIOD_W-1); data_valid<=1; locked<=1; cnt<=0, hcnt<=0 (next frame begins next cycle, free-running).
  3. else: cnt<=cnt+1, hcnt<=hcnt+s.
- rise at cnt==0 is the expected frame start: counted normally, no error.
- Duty 0 after lock: no edges, frames free-run, data_out=0 each frame, locked stays 1.
- Line stuck high for a full frame: total=256 -> saturates to 255.
- Never-toggling line before lock: stays IDLE, no data_valid.
- en=0 (sync): state<=IDLE, counters cleared, locked<=0, data_valid/sync_err<=0; data_out holds last value. Synchronizer keeps running. en 0->1 requires fresh rise.
- Latency: data_valid asserted 1 cycle after last frame sample leaves synchronizer; pin-to-valid = SYNC_STAGES+1 cycles after last frame cycle at pin.
- data_valid and sync_err never asserted in the same cycle.

Optional Feature:
PWM_GLITCH_FILTER_EN: defined -> 3-sample majority filter between synchronizer and edge detect; adds 2 cycles latency; single-cycle pulses suppressed, so transmitted 1 reads as 0 and 255 reads as 255 via saturation (line appears stuck high). Undefined -> s taken directly from synchronizer; all values 0..255 recovered exactly.

Test Plan:
1. Release rst, en=1, transmitter sends 128 continuously -> first frame after the first rise gives data_valid with data_out=128, locked=1; then one strobe every 256 cycles, value 128.
2. After lock, switch to 0 -> data_out=0 each frame, locked remains 1, no sync_err.
3. Send 255, then force pwm_in=1 for 512 cycles -> data_out=255 every frame, no overflow wrap to 0.
4. While locked at 100, inject extra rising edge at cnt=100 -> sync_err pulse, locked=0, no data_valid for aborted frame; after realignment, next complete frame gives data_out equal to that frame's high count and locked=1.
5. Drive rst=0 mid-frame, between clock edges -> data_out=0, data_valid=0, locked=0 immediately; after release, relock on next rise.
6. Drop en for 10 cycles mid-frame -> no strobes, locked=0, data_out holds 128; re-enable -> relock on next rise, data_out=128.
